// File: rtl/branch_exec_if.sv
// branch_exec_if: groups the branch-issue, SPR-write and result signals of the
// branch execution stage into one bundle.
//   master : the identify stage / SPR source side (drives i_*, observes o_*)
//   slave  : branch_exec itself (observes i_*, drives o_*)
// Handshake: i_en marks a branch in the cycle it is sampled. o_valid pulses for
// exactly one cycle per sampled branch, one edge later. There is no ready and
// no backpressure, so the consumer must take every o_valid pulse.
// Bit numbering is big-endian ([0] is the most significant bit).
interface branch_exec_if;
  logic        i_en;
  logic [0:31] i_instr;
  logic        i_i_form;
  logic        i_b_form;
  logic        i_cond_LR;
  logic        i_cond_CTR;
  logic        i_cond_TAR;
  logic [0:63] i_cia;
  logic [0:31] i_cr;
  logic        i_spr_we;
  logic [0:1]  i_spr_sel;
  logic [0:63] i_spr_wdata;
  logic        o_valid;
  logic        o_taken;
  logic [0:63] o_nia;
  logic        o_invalid;
  logic [0:63] o_lr;
  logic [0:63] o_ctr;
  logic [0:63] o_tar;

  modport master (
    output i_en, i_instr, i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR,
           i_cia, i_cr, i_spr_we, i_spr_sel, i_spr_wdata,
    input  o_valid, o_taken, o_nia, o_invalid, o_lr, o_ctr, o_tar
  );

  modport slave (
    input  i_en, i_instr, i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR,
           i_cia, i_cr, i_spr_we, i_spr_sel, i_spr_wdata,
    output o_valid, o_taken, o_nia, o_invalid, o_lr, o_ctr, o_tar
  );
endinterface

// File: rtl/branch_exec.sv
// branch_exec: branch execution stage. Evaluates I-form, B-form, bclr, bcctr
// and bctar branches against CR/CTR/LR/TAR and returns a registered next
// instruction address one cycle after the branch is sampled. Owns the LR, CTR
// and (optionally) TAR architectural registers and accepts move-to-SPR writes.
// Ports:
//   i_clk  : core clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : branch_exec_if.slave (branch in, SPR write in, result and
//            architectural register values out)
// Configuration macro BRU_TAR_EN: when defined, TAR storage, bctar and SPR
// select 10 are supported; when undefined, o_tar reads 0, bctar reports
// invalid and SPR writes to select 10 are dropped.
module branch_exec (
  input  logic          i_clk,
  input  logic          i_rst,
  branch_exec_if.slave  bus
);

  // Instruction fields (big-endian numbering)
  logic [0:4]  bo;
  logic [0:4]  bi;
  logic        aa;
  logic        lk;
  assign bo = bus.i_instr[6:10];
  assign bi = bus.i_instr[11:15];
  assign aa = bus.i_instr[30];
  assign lk = bus.i_instr[31];

  // Architectural state
  logic [0:63] lr_q;
  logic [0:63] ctr_q;
  logic [0:63] tar_val;
  logic        tar_en;

`ifdef BRU_TAR_EN
  logic [0:63] tar_q;
  assign tar_val = tar_q;
  assign tar_en  = 1'b1;
`else
  assign tar_val = '0;
  assign tar_en  = 1'b0;
`endif

  // Result registers
  logic        valid_q;
  logic        taken_q;
  logic        invalid_q;
  logic [0:63] nia_q;

  // Decode / evaluate
  logic [0:63] li_off;
  logic [0:63] bd_off;
  logic [0:63] seq_nia;
  logic [0:63] ctr_new;
  logic [0:63] target;
  logic [0:63] nia_d;
  logic        conditional;
  logic        invalid;
  logic        commit;
  logic        ctr_ok;
  logic        cond_ok;
  logic        taken;
  logic        taken_d;
  logic        lr_upd;
  logic        ctr_upd;

  // Sign-extended displacements with the two implied zero bits appended.
  assign li_off  = {{38{bus.i_instr[6]}}, bus.i_instr[6:29], 2'b00};
  assign bd_off  = {{48{bus.i_instr[16]}}, bus.i_instr[16:29], 2'b00};
  assign seq_nia = bus.i_cia + 64'd4;

  always_comb begin
    conditional = bus.i_b_form | bus.i_cond_LR | bus.i_cond_CTR | bus.i_cond_TAR;

    // bcctr cannot decrement CTR and branch through it at the same time, so a
    // decrementing bcctr is rejected; bctar is rejected when TAR is absent.
    invalid = bus.i_en &
              (~$onehot({bus.i_i_form, bus.i_b_form, bus.i_cond_LR,
                         bus.i_cond_CTR, bus.i_cond_TAR}) |
               (bus.i_cond_CTR & ~bo[2]) |
               (bus.i_cond_TAR & ~tar_en));
    commit = bus.i_en & ~invalid;

    ctr_new = bo[2] ? ctr_q : (ctr_q - 64'd1);
    ctr_ok  = bo[2] | ((ctr_new != 64'd0) ^ bo[3]);
    cond_ok = bo[0] | (bus.i_cr[bi] == bo[1]);
    taken   = bus.i_i_form | (ctr_ok & cond_ok);

    target = seq_nia;
    if (bus.i_i_form) begin
      target = aa ? li_off : (bus.i_cia + li_off);
    end else if (bus.i_b_form) begin
      target = aa ? bd_off : (bus.i_cia + bd_off);
    end else if (bus.i_cond_LR) begin
      target = {lr_q[0:61], 2'b00};
    end else if (bus.i_cond_CTR) begin
      target = {ctr_q[0:61], 2'b00};
    end else if (bus.i_cond_TAR) begin
      target = {tar_val[0:61], 2'b00};
    end

    taken_d = commit & taken;
    nia_d   = taken_d ? target : seq_nia;

    // Link and CTR updates happen on any valid branch, taken or not.
    lr_upd  = commit & lk;
    ctr_upd = commit & conditional & ~bo[2];
  end

  // Results
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      invalid_q <= 1'b0;
      nia_q     <= '0;
    end else begin
      valid_q   <= bus.i_en;
      taken_q   <= taken_d;
      invalid_q <= invalid;
      if (bus.i_en) begin
        nia_q <= nia_d;
      end
    end
  end

  // LR / CTR: the SPR write is applied first so that a branch update of the
  // same register in the same cycle overrides it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lr_q  <= '0;
      ctr_q <= '0;
    end else begin
      if (bus.i_spr_we && bus.i_spr_sel == 2'b00) begin
        lr_q <= bus.i_spr_wdata;
      end
      if (lr_upd) begin
        lr_q <= seq_nia;
      end
      if (bus.i_spr_we && bus.i_spr_sel == 2'b01) begin
        ctr_q <= bus.i_spr_wdata;
      end
      if (ctr_upd) begin
        ctr_q <= ctr_new;
      end
    end
  end

`ifdef BRU_TAR_EN
  // No branch ever writes TAR, so only the SPR port updates it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tar_q <= '0;
    end else if (bus.i_spr_we && bus.i_spr_sel == 2'b10) begin
      tar_q <= bus.i_spr_wdata;
    end
  end
`endif

  assign bus.o_valid   = valid_q;
  assign bus.o_taken   = taken_q;
  assign bus.o_invalid = invalid_q;
  assign bus.o_nia     = nia_q;
  assign bus.o_lr      = lr_q;
  assign bus.o_ctr     = ctr_q;
  assign bus.o_tar     = tar_val;

  // Opcode bits are decoded upstream; low TAR bits never form an address.
  logic unused_bits;
  assign unused_bits = ^{bus.i_instr[0:5], tar_val[62:63]};

endmodule

// File: tb/tb_branch_exec.sv
// tb_branch_exec: self-checking bench for branch_exec. Directed cases plus
// randomized branches and SPR writes, checked against a behavioural model of
// the branch rules through an expected-result queue and an independent monitor.
module tb_branch_exec;

  typedef struct {
    bit          valid;
    bit          taken;
    bit          invalid;
    logic [63:0] nia;
    logic [63:0] lr;
    logic [63:0] ctr;
    logic [63:0] tar;
  } exp_t;

`ifdef BRU_TAR_EN
  localparam bit TAR_ON = 1'b1;
`else
  localparam bit TAR_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // Reference model state
  logic [63:0] m_lr;
  logic [63:0] m_ctr;
  logic [63:0] m_tar;

  branch_exec_if bus ();

  branch_exec dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    logic [63:0] one;
    one = 64'd1;
    if (((v >> (bits - 1)) & one) != 0) return v - (one << bits);
    return v;
  endfunction

  // Driver: applies one cycle of stimulus at the falling edge and pushes the
  // model's prediction of what the DUT shows after the next rising edge.
  // flags = {i_form, b_form, cond_LR, cond_CTR, cond_TAR}
  task automatic drive(input bit en, input logic [31:0] instr, input logic [4:0] flags,
                       input logic [63:0] cia, input logic [31:0] cr, input bit we,
                       input logic [1:0] sel, input logic [63:0] wd);
    exp_t        e;
    int          bo, bi, aa, lk;
    bit          bad, tk, b0, b1, b2, b3, crbit, ctr_ok, cond_ok;
    logic [63:0] tgt, new_ctr;
    @(negedge clk);
    bus.i_en        = en;
    bus.i_instr     = instr;
    bus.i_i_form    = flags[4];
    bus.i_b_form    = flags[3];
    bus.i_cond_LR   = flags[2];
    bus.i_cond_CTR  = flags[1];
    bus.i_cond_TAR  = flags[0];
    bus.i_cia       = cia;
    bus.i_cr        = cr;
    bus.i_spr_we    = we;
    bus.i_spr_sel   = sel;
    bus.i_spr_wdata = wd;

    bo = int'((instr >> 21) & 32'd31);
    bi = int'((instr >> 16) & 32'd31);
    aa = int'((instr >> 1) & 32'd1);
    lk = int'(instr & 32'd1);
    b0 = ((bo >> 4) & 1) != 0;
    b1 = ((bo >> 3) & 1) != 0;
    b2 = ((bo >> 2) & 1) != 0;
    b3 = ((bo >> 1) & 1) != 0;
    crbit = ((cr >> (31 - bi)) & 32'd1) != 0;

    bad = en && (($countones(flags) != 1) || (flags[1] && !b2) || (flags[0] && !TAR_ON));
    tk  = 1'b0;
    tgt = cia + 64'd4;
    new_ctr = b2 ? m_ctr : m_ctr - 64'd1;
    if (en && !bad) begin
      if (flags[4]) begin
        tk  = 1'b1;
        tgt = sext(64'((instr >> 2) & 32'hFF_FFFF) << 2, 26);
        if (aa == 0) tgt = tgt + cia;
      end else begin
        ctr_ok  = b2 || ((new_ctr != 0) != b3);
        cond_ok = b0 || (crbit == b1);
        tk      = ctr_ok && cond_ok;
        if (flags[3]) begin
          tgt = sext(64'((instr >> 2) & 32'h3FFF) << 2, 16);
          if (aa == 0) tgt = tgt + cia;
        end else if (flags[2]) tgt = m_lr & ~64'h3;
        else if (flags[1]) tgt = m_ctr & ~64'h3;
        else tgt = m_tar & ~64'h3;
      end
    end
    e.valid   = en;
    e.invalid = bad;
    e.taken   = tk;
    e.nia     = tk ? tgt : cia + 64'd4;

    // State: SPR write first, branch updates take priority.
    if (we && sel == 2'd0) m_lr = wd;
    if (we && sel == 2'd1) m_ctr = wd;
    if (we && sel == 2'd2 && TAR_ON) m_tar = wd;
    if (en && !bad) begin
      if (lk == 1) m_lr = cia + 64'd4;
      if (!flags[4] && !b2) m_ctr = new_ctr;
    end
    e.lr  = m_lr;
    e.ctr = m_ctr;
    e.tar = m_tar;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 5'd0, 64'd0, 32'd0, 1'b0, 2'd0, 64'd0);
  endtask

  task automatic spr(input logic [1:0] sel, input logic [63:0] wd);
    drive(1'b0, 32'd0, 5'd0, 64'd0, 32'd0, 1'b1, sel, wd);
  endtask

  task automatic br(input logic [31:0] instr, input logic [4:0] flags,
                    input logic [63:0] cia, input logic [31:0] cr);
    drive(1'b1, instr, flags, cia, cr, 1'b0, 2'd0, 64'd0);
  endtask

  // Monitor: one rising edge after each pushed cycle the DUT must present
  // the predicted result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("o_valid", 64'(bus.o_valid), 64'(e.valid));
          if (bus.o_valid) begin
            chk("o_taken", 64'(bus.o_taken), 64'(e.taken));
            chk("o_invalid", 64'(bus.o_invalid), 64'(e.invalid));
            chk("o_nia", bus.o_nia, e.nia);
          end
          chk("o_lr", bus.o_lr, e.lr);
          chk("o_ctr", bus.o_ctr, e.ctr);
          chk("o_tar", bus.o_tar, e.tar);
        end else if (bus.o_valid) begin
          chk("spurious o_valid", 64'(bus.o_valid), 64'd0);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " o_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, " o_taken"}, 64'(bus.o_taken), 64'd0);
    chk({tag, " o_invalid"}, 64'(bus.o_invalid), 64'd0);
    chk({tag, " o_nia"}, bus.o_nia, 64'd0);
    chk({tag, " o_lr"}, bus.o_lr, 64'd0);
    chk({tag, " o_ctr"}, bus.o_ctr, 64'd0);
    chk({tag, " o_tar"}, bus.o_tar, 64'd0);
  endtask

  initial begin
    logic [4:0]  fl;
    logic [63:0] cia, wd;
    int          r;
    checks = 0;
    errors = 0;
    m_lr = '0; m_ctr = '0; m_tar = '0;
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_instr = '0; bus.i_i_form = 1'b0; bus.i_b_form = 1'b0;
    bus.i_cond_LR = 1'b0; bus.i_cond_CTR = 1'b0; bus.i_cond_TAR = 1'b0;
    bus.i_cia = '0; bus.i_cr = '0; bus.i_spr_we = 1'b0; bus.i_spr_sel = '0;
    bus.i_spr_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    br(32'h48032BFB, 5'b10000, 64'h1000, 32'd0);      // I-form, absolute, link
    spr(2'd1, 64'd2);
    br(32'h4200FFF8, 5'b01000, 64'h2000, 32'd0);      // bdnz -8, taken
    br(32'h4200FFF8, 5'b01000, 64'h2000, 32'd0);      // bdnz -8, CTR reaches 0
    spr(2'd0, 64'h4000);
    br(32'h4E800021, 5'b00100, 64'h3000, 32'd0);      // blrl
    spr(2'd1, 64'd7);
    br(32'h4C000420, 5'b00010, 64'h5000, 32'd0);      // bcctr BO=0: invalid
    spr(2'd1, 64'd9);
    drive(1'b1, 32'h4200FFF8, 5'b01000, 64'h6000, 32'd0, 1'b1, 2'd1, 64'h55);
    spr(2'd0, 64'h80);
    idle();
    spr(2'd2, 64'h1234);
    br(32'h4E800460, 5'b00001, 64'h7000, 32'd0);      // bctar, BO=20
    br(32'h4E800420, 5'b00010, 64'h7100, 32'd0);      // bctr, BO=20
    br(32'h48000001, 5'b00000, 64'h7200, 32'd0);      // no form flag
    br(32'h48000001, 5'b11000, 64'h7300, 32'd0);      // two form flags
    br(32'h4BFFFFF8, 5'b10000, 64'h4, 32'd0);         // relative wrap below 0
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 17) fl = 5'b10000 >> (r % 5);
      else fl = 5'($urandom);
      cia = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 9) == 0) cia = 64'hFFFF_FFFF_FFFF_FFFC;
      wd = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0, $urandom, fl, cia, $urandom,
            $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), wd);
    end

    // Asynchronous reset while a result is on the outputs
    spr(2'd0, 64'h9000);
    spr(2'd1, 64'h33);
    br(32'h4E800021, 5'b00100, 64'h8000, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async reset");
    exp_q.delete();
    m_lr = '0; m_ctr = '0; m_tar = '0;
    bus.i_en = 1'b0;
    bus.i_spr_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    br(32'h4E800021, 5'b00100, 64'hA000, 32'd0);      // blrl sees cleared LR
    idle();

    repeat (3) @(posedge clk);
    #2;
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
